// File: rtl/segway_pkg.sv
// Shared types and constants for the segway rider-presence / steering-enable logic.
package segway_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        STEER = 2'b10
    } steer_state_t;

    localparam logic [11:0] MIN_RIDER_WT_DFLT = 12'h200;
    localparam logic [11:0] WT_HYST_DFLT      = 12'h040;

    localparam int TMR_W_FULL = 26;
    localparam int TMR_W_SIM  = 15;

    function automatic int steer_tmr_width(input bit fast_sim);
        return fast_sim ? TMR_W_SIM : TMR_W_FULL;
    endfunction

endpackage

// File: rtl/steer_tmr.sv
// Settle timer: up-counter with synchronous clear that saturates at all-ones.
module steer_tmr #(
    parameter int W = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic full
);

    logic [W-1:0] cnt;

    assign full = &cnt;

    // Holding at all-ones keeps full asserted until the next clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (!full)
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/steer_en_sm.sv
// Rider-presence and steering-enable controller fed by the left/right load-cell conversions.
//
//   state | meaning
//   IDLE  | no rider; rider_off high, PID integrator held at zero
//   WAIT  | rider present, waiting for continuous balance over the settle time
//   STEER | rider settled; en_steer high, steering pot allowed into the mixer
module steer_en_sm
    import segway_pkg::*;
#(
    parameter bit          FAST_SIM     = 1'b0,
    parameter logic [11:0] MIN_RIDER_WT = MIN_RIDER_WT_DFLT,
    parameter logic [11:0] WT_HYST      = WT_HYST_DFLT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    localparam int          TMR_W  = steer_tmr_width(FAST_SIM);
    localparam logic [12:0] THR_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
    localparam logic [12:0] THR_LO = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    steer_state_t state_q, state_d;

    logic [12:0] sum;
    logic [11:0] abs_diff;
    logic [12:0] sum_qtr;
    logic [12:0] sum_15_16;
    logic        sum_gt_min;
    logic        sum_lt_min;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;
    logic        clr_tmr;
    logic        tmr_full;

    assign sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
    assign abs_diff = (lft_ld < rght_ld) ? (rght_ld - lft_ld) : (lft_ld - rght_ld);

    assign sum_qtr   = {2'b00, sum[12:2]};
    assign sum_15_16 = sum - {4'b0000, sum[12:4]};

    assign sum_gt_min    = (sum > THR_HI);
    assign sum_lt_min    = (sum < THR_LO);
    assign diff_gt_1_4   = ({1'b0, abs_diff} > sum_qtr);
    assign diff_gt_15_16 = ({1'b0, abs_diff} > sum_15_16);

    steer_tmr #(
        .W (TMR_W)
    ) u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_tmr),
        .full  (tmr_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Weight loss outranks every balance and timer condition.
    always_comb begin
        state_d = state_q;
        clr_tmr = 1'b0;
        case (state_q)
            IDLE: begin
                if (sum_gt_min) begin
                    state_d = WAIT;
                    clr_tmr = 1'b1;
                end
            end
            WAIT: begin
                if (sum_lt_min)
                    state_d = IDLE;
                else if (diff_gt_1_4)
                    clr_tmr = 1'b1;
                else if (tmr_full)
                    state_d = STEER;
            end
            STEER: begin
                if (sum_lt_min)
                    state_d = IDLE;
                else if (diff_gt_15_16) begin
                    state_d = WAIT;
                    clr_tmr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign en_steer  = (state_q == STEER);
    assign rider_off = (state_q == IDLE);

endmodule

// File: tb/tb_steer_en_sm.sv
// Directed bench for steer_en_sm with the 15-bit simulation timer.
module tb_steer_en_sm;

    localparam int PERIOD = 32768;

    logic        clk;
    logic        rst_n;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    int n_chk;
    int n_bad;

    steer_en_sm #(
        .FAST_SIM     (1'b1),
        .MIN_RIDER_WT (12'h200),
        .WT_HYST      (12'h040)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .en_steer  (en_steer),
        .rider_off (rider_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
    endtask

    initial begin
        n_chk   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        lft_ld  = 12'h000;
        rght_ld = 12'h000;

        // Reset with no load
        tick(3);
        chk("rst_rider_off", rider_off, 1);
        chk("rst_en_steer", en_steer, 0);
        rst_n = 1'b1;
        tick(100);
        chk("idle100_rider_off", rider_off, 1);
        chk("idle100_en_steer", en_steer, 0);

        // Balanced step: outputs move only on the next edge
        drive(12'h180, 12'h180);
        #1;
        chk("step_no_comb_path", rider_off, 1);
        tick(1);
        chk("step_wait_rider_off", rider_off, 0);
        chk("step_wait_en_steer", en_steer, 0);

        // Reset mid-WAIT is asynchronous
        tick(1000);
        rst_n = 1'b0;
        #2;
        chk("async_rst_rider_off", rider_off, 1);
        chk("async_rst_en_steer", en_steer, 0);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_wait", rider_off, 0);

        // Full settle period from WAIT entry
        tick(PERIOD - 1);
        chk("settle_edge_minus1", en_steer, 0);
        tick(1);
        chk("settle_edge_steer", en_steer, 1);
        chk("settle_rider_off", rider_off, 0);

        // Imbalance exactly at 15/16 boundary keeps STEER
        drive(12'h2E8, 12'h018);
        tick(3);
        chk("diff_eq_15_16_hold", en_steer, 1);

        // Imbalance beyond 15/16 drops to WAIT
        drive(12'h2F8, 12'h008);
        tick(1);
        chk("diff_gt_15_16_en", en_steer, 0);
        chk("diff_gt_15_16_rider", rider_off, 0);
        tick(4);
        chk("imbal_hold_wait", en_steer, 0);

        // Restore balance; timer cleared on the last imbalanced edge
        drive(12'h180, 12'h180);
        tick(20000);
        chk("wait_20000", en_steer, 0);

        // One-cycle 1/4 imbalance glitch restarts the timer
        drive(12'h200, 12'h100);
        tick(1);
        drive(12'h180, 12'h180);
        chk("glitch_rider_off", rider_off, 0);
        tick(PERIOD - 20001);
        chk("glitch_orig_deadline", en_steer, 0);
        tick(20000);
        chk("glitch_edge_minus1", en_steer, 0);
        tick(1);
        chk("glitch_edge_steer", en_steer, 1);

        // Weight loss from STEER goes straight to IDLE
        drive(12'h0D0, 12'h0D0);
        tick(1);
        chk("lowwt_rider_off", rider_off, 1);
        chk("lowwt_en_steer", en_steer, 0);

        // Inside hysteresis band: no transition out of IDLE
        drive(12'h108, 12'h108);
        tick(100);
        chk("band_0x210_idle", rider_off, 1);
        drive(12'h120, 12'h120);
        tick(5);
        chk("band_0x240_idle", rider_off, 1);
        drive(12'h121, 12'h120);
        tick(1);
        chk("above_0x241_wait", rider_off, 0);

        // Lower band edge from WAIT
        drive(12'h0E0, 12'h0E0);
        tick(5);
        chk("band_0x1c0_wait", rider_off, 0);
        drive(12'h0E0, 12'h0DF);
        tick(1);
        chk("below_0x1bf_idle", rider_off, 1);
        chk("below_0x1bf_en", en_steer, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/steer_en_sm.md
# steer_en_sm

Rider-presence and steering-enable controller sitting directly downstream of the A2D interface. It consumes the left and right load-cell conversions and qualifies them with a weight threshold, a balance check and a settle timer. It produces `en_steer`, which gates steering-pot use in the balance/steer mixer, and `rider_off`, which tells the PID to zero its integrator and drive motors to zero.

## Interface
Parameters:
- `FAST_SIM`, default 0: 1 selects the 15-bit timer for simulation; 0 selects the 26-bit timer (~1.34 s at 50 MHz).
- `MIN_RIDER_WT`, default 12'h200: nominal combined-load threshold.
- `WT_HYST`, default 12'h040: hysteresis half-band around `MIN_RIDER_WT`.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset; clock is `clk`.
- `lft_ld` in 12: left load cell (unsigned), held until next conversion.
- `rght_ld` in 12: right load cell (unsigned), held until next conversion.
- `en_steer` out 1: high only in STEER.
- `rider_off` out 1: high only in IDLE.

## Operation
- `sum` = `lft_ld + rght_ld`, 13 bits unsigned. Never truncate.
- `diff` = `lft_ld - rght_ld`, 13-bit signed. `abs_diff` is 12-bit unsigned.
- `sum_gt_min` = `sum > MIN_RIDER_WT + WT_HYST` (13-bit compare).
- `sum_lt_min` = `sum < MIN_RIDER_WT - WT_HYST`.
- `diff_gt_1_4` = `abs_diff > sum>>2`.
- `diff_gt_15_16` = `abs_diff > (sum - sum>>4)`, computed at 13 bits.
- Timer: up-counter with synchronous `clr_tmr`. It saturates at all-ones. `tmr_full` = all ones over 26 bits, or over 15 bits when `FAST_SIM`=1.
- Conditions are evaluated every clock. There is no valid strobe: inputs are treated as level data.

States (enum IDLE, WAIT, STEER):
- IDLE: if `sum_gt_min`, go to WAIT and assert `clr_tmr`.
- WAIT:
  - `sum_lt_min` → IDLE.
  - Else if `diff_gt_1_4`, assert `clr_tmr` and stay in WAIT.
  - Else if `tmr_full` → STEER.
  - Else stay in WAIT.
- STEER:
  - `sum_lt_min` → IDLE.
  - Else if `diff_gt_15_16` → WAIT and assert `clr_tmr`.
  - Else stay in STEER.
- Illegal encoding → IDLE.

Simultaneous events and priorities:
- `sum_lt_min` has priority over the diff checks and over `tmr_full`.
- In WAIT, if `diff_gt_1_4` and `tmr_full` are both true, the state stays WAIT and the timer clears.

## Timing
- Reset values: state=IDLE, timer=0, `en_steer`=0, `rider_off`=1.
- Outputs are Moore-decoded from the state register, with no combinational path from the inputs.
- An input change affects the outputs one clock later. Output changes occur exactly on the clock edge where the state changes.
- Timer starts counting the cycle after `clr_tmr`.
- WAIT→STEER happens on the edge after the timer reaches full. Entry to WAIT through `en_steer` assertion takes 2^N cycles of continuous balance (N=26 or 15).
- Timer saturates and never wraps.
- Reset asserted mid-WAIT or mid-STEER forces IDLE and timer=0 asynchronously. After reset deasserts, operation resumes from IDLE.
- Hysteresis: a sum between `MIN-HYST` and `MIN+HYST` causes no IDLE transition in either direction.

## Structure
- Shared package `segway_pkg`:
  - `steer_state_t` enum.
  - `MIN_RIDER_WT` and `WT_HYST` default constants.
  - Timer widths 26/15.
- Sub-module `steer_tmr`, parameterised width: counter with clear, saturation and a `full` flag.
- Arithmetic and comparators live in the top level, as does the state machine.

## Test plan
All scenarios use FAST_SIM=1.
1. Reset with `lft`=`rght`=0 → `rider_off`=1, `en_steer`=0. Hold 100 cycles; no change.
2. Step to `lft`=`rght`=12'h180 (sum 0x300) → `rider_off`=0 one clock later. `en_steer` rises exactly 32768 cycles after WAIT entry (±1 for registration).
3. In WAIT at cycle 20000, set `lft`=12'h200, `rght`=12'h100 (diff 0x100 > 0x300>>2=0xC0) for 1 cycle, then restore → timer restarts. `en_steer` is delayed by the full 32768 cycles from the restore.
4. In STEER, set `lft`=12'h2F8, `rght`=12'h008 (diff 0x2F0 > 0x2D0) → `en_steer`=0 next cycle, state WAIT, `rider_off` stays 0.
5. In STEER, drop to `lft`=`rght`=12'h0D0 (sum 0x1A0 < 0x1C0) → IDLE, `rider_off`=1, `en_steer`=0. Then sum 0x210 (inside band) → stays IDLE.
6. Assert `rst_n`=0 mid-count in WAIT, release with balanced load 0x300 → IDLE, then WAIT, and the full timer period elapses again before STEER.
